c_result_packer: RTL and testbench
==================================

Name: c_result_packer

Overview:
- Collects the stream of ELEM_W-bit result elements from the systolic array output.
- Packs ELEMS_PER_BEAT elements into one BEAT_W-bit beat and writes the beats sequentially into BRAM C from address 0.
- Sits directly upstream of the DMA store path. Its done pulse tells the controller that BRAM C holds num_beats valid beats and start_store_c may be issued.

Parameters:
- ELEM_W, 32, width of one result element (signed two's complement).
- BEAT_W, 128, BRAM C word width; must equal the DMA beat width and be a multiple of ELEM_W.
- LENGTH_W, 8, width of the beat-count fields.
- BRAM_AW, 8, BRAM C address width; must be >= LENGTH_W.
- ELEMS_PER_BEAT (localparam), BEAT_W/ELEM_W; default 4.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a job; sampled only in IDLE.
- num_beats  in  LENGTH_W  beats to produce; latched on start.
- in_valid  in  1  element valid.
- in_ready  out  1  element accepted when in_valid && in_ready.
- in_data  in  ELEM_W  result element.
- in_last  in  1  marks the final element of the job.
- bram_c_addr  out  BRAM_AW  write address.
- bram_c_en  out  1  port enable.
- bram_c_we  out  1  write strobe.
- bram_c_wdata  out  BEAT_W  packed beat.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- err_short  out  1  sticky flag: in_last arrived early; cleared on the next accepted start.
- beats_written  out  LENGTH_W  beats committed in the current/last job.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: all outputs 0. State = IDLE, lane counter = 0, beat index = 0, accumulation register = 0. A reset mid-job discards the partial beat and performs no write.
- States: IDLE, RUN, FLUSH, FIN.
- IDLE:
  - in_ready = 0.
  - start with num_beats != 0: latch num_beats, clear beat index, lane counter, err_short and beats_written; go to RUN; busy = 1 from the next cycle.
  - start with num_beats == 0: done pulses the next cycle and the block stays IDLE with no writes.
- Lane packing: in RUN, in_ready = 1. Each accepted element goes to lane k = lane counter, bits [ELEM_W*k +: ELEM_W]; lane 0 is the LSB. The lane counter then increments.
- Beat write on the lane ELEMS_PER_BEAT-1 accept:
  - The completed beat (including that element) is copied to a separate write register.
  - Registered write: bram_c_en = bram_c_we = 1 on the next cycle, with addr = beat index zero-extended.
  - The accumulation register clears to 0 and the lane counter to 0.
  - Accepts continue every cycle, so a new beat can fill while the previous one writes. Sustained throughput is 1 element/cycle.
- beats_written increments in the same cycle as each write strobe.
- Normal completion: the accept that fills beat num_beats-1 moves the block to FIN. FIN holds the final write strobe for one cycle. On the following cycle done = 1 and busy = 0, and the block returns to IDLE. Whether in_last accompanies that final element is ignored.
- Early in_last (accepted before the final element):
  - Lane counter != 0 after the accept: go to FLUSH, which writes the partial beat with unfilled lanes zero.
  - Lane counter == 0: the beat is already written, so go straight to FIN behaviour.
  - Either way err_short = 1 and termination follows as normal, with done one cycle after the last write.
- Elements are never accepted outside RUN. start while busy is ignored.
- Arithmetic: beat index and beats_written are LENGTH_W bits and cannot wrap, because the beat count is <= 2^LENGTH_W-1.
- Latency: last element accepted at cycle T, BRAM write at T+1, done at T+2.

Optional Feature:
- Macro C_PACK_RELU_EN.
- Defined: each element is replaced with 0 before packing if its MSB is 1 (signed negative); all other behaviour is unchanged.
- Undefined: elements are packed unmodified.

Decomposition:
- Shared package mm_pkg holds:
  - the state enum (IDLE/RUN/FLUSH/FIN);
  - the default BEAT_W/ELEM_W/LENGTH_W/BRAM_AW constants, shared with the DMA master;
  - the ELEMS_PER_BEAT derivation.
- No sub-module; the lane-insert logic is a single always block.

Test Plan:
- num_beats=2, 8 back-to-back elements 0x1..0x8 → write addr0 = 0x00000004_00000003_00000002_00000001 and addr1 = 0x8_7_6_5 lanes; done 2 cycles after element 8 is accepted; err_short=0; beats_written=2.
- num_beats=3, elements 1..6 with in_last on element 6 → addr1 = {0,0,6,5}; err_short=1; done; no addr2 write.
- in_valid toggling 1/0 with num_beats=1 → one write only after the 4th accept, lanes correct.
- start with num_beats=0 → done the next cycle, busy never rises, no bram_c_we.
- rst asserted after 2 elements of a beat → no write, all outputs 0. A fresh start then packs from lane 0.
- With C_PACK_RELU_EN defined: elements -5, 7, 0x80000000, 3 → beat lanes {3,0,7,0}.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared constants and types for the matrix-multiply datapath: FSM states,
// default bus widths (common with the DMA master) and the beat packing ratio.
package mm_pkg;

    localparam int unsigned MM_ELEM_W   = 32;
    localparam int unsigned MM_BEAT_W   = 128;
    localparam int unsigned MM_LENGTH_W = 8;
    localparam int unsigned MM_BRAM_AW  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        FIN   = 2'd3
    } mm_state_e;

    // Number of result elements carried by one BRAM C beat.
    function automatic int unsigned elems_per_beat(input int unsigned beat_w,
                                                   input int unsigned elem_w);
        return beat_w / elem_w;
    endfunction

    localparam int unsigned MM_ELEMS_PER_BEAT = elems_per_beat(MM_BEAT_W, MM_ELEM_W);

endpackage

// File: rtl/c_result_packer_if.sv
// Result element stream from the systolic array into the C result packer.
interface c_result_packer_if
    import mm_pkg::*;
#(
    parameter int unsigned ELEM_W = MM_ELEM_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [ELEM_W-1:0] in_data;
    logic              in_last;

    modport master (output in_valid, output in_data, output in_last, input  in_ready);
    modport slave  (input  in_valid, input  in_data, input  in_last, output in_ready);

endinterface

// File: rtl/c_result_packer.sv
// Packs ELEM_W-bit result elements into BEAT_W-bit beats written to BRAM C from address 0.
// Optional build macro C_PACK_RELU_EN: negative elements are zeroed before packing.
module c_result_packer
    import mm_pkg::*;
#(
    parameter int unsigned ELEM_W   = MM_ELEM_W,
    parameter int unsigned BEAT_W   = MM_BEAT_W,
    parameter int unsigned LENGTH_W = MM_LENGTH_W,
    parameter int unsigned BRAM_AW  = MM_BRAM_AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LENGTH_W-1:0] num_beats,
    c_result_packer_if.slave    s_in,
    output logic [BRAM_AW-1:0]  bram_c_addr,
    output logic                bram_c_en,
    output logic                bram_c_we,
    output logic [BEAT_W-1:0]   bram_c_wdata,
    output logic                busy,
    output logic                done,
    output logic                err_short,
    output logic [LENGTH_W-1:0] beats_written
);

    localparam int unsigned EPB    = elems_per_beat(BEAT_W, ELEM_W);
    localparam int unsigned LANE_W = (EPB > 1) ? $clog2(EPB) : 1;

    mm_state_e           r_state;
    logic [LANE_W-1:0]   r_lane;
    logic [LENGTH_W-1:0] r_beat_idx;
    logic [LENGTH_W-1:0] r_num_beats;
    logic [BEAT_W-1:0]   r_acc;
    logic [BEAT_W-1:0]   r_wdata;
    logic [BRAM_AW-1:0]  r_addr;
    logic                r_en;
    logic                r_we;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_in_ready;
    logic [LENGTH_W-1:0] r_beats_written;

    logic [ELEM_W-1:0]   w_elem;
    logic [BEAT_W-1:0]   w_beat;
    logic                w_accept;
    logic                w_lane_full;
    logic                w_final;

    assign w_accept    = s_in.in_valid && r_in_ready;
    assign w_lane_full = (r_lane == LANE_W'(EPB - 1));
    assign w_final     = (r_beat_idx == (r_num_beats - LENGTH_W'(1)));

    // Current beat with the incoming element dropped into its lane.
    always_comb begin : lane_insert
        w_elem = s_in.in_data;
`ifdef C_PACK_RELU_EN
        if (s_in.in_data[ELEM_W-1]) begin
            w_elem = '0;
        end
`endif
        w_beat = r_acc;
        for (int unsigned k = 0; k < EPB; k++) begin
            if (r_lane == LANE_W'(k)) begin
                w_beat[k*ELEM_W +: ELEM_W] = w_elem;
            end
        end
    end

    always_ff @(posedge clk) begin : fsm
        if (rst) begin
            r_state         <= IDLE;
            r_lane          <= '0;
            r_beat_idx      <= '0;
            r_num_beats     <= '0;
            r_acc           <= '0;
            r_wdata         <= '0;
            r_addr          <= '0;
            r_en            <= 1'b0;
            r_we            <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
            r_in_ready      <= 1'b0;
            r_beats_written <= '0;
        end else begin
            r_en   <= 1'b0;
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (num_beats != '0) begin
                            r_num_beats     <= num_beats;
                            r_beat_idx      <= '0;
                            r_lane          <= '0;
                            r_acc           <= '0;
                            r_err           <= 1'b0;
                            r_beats_written <= '0;
                            r_busy          <= 1'b1;
                            r_in_ready      <= 1'b1;
                            r_state         <= RUN;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        if (w_lane_full) begin
                            // Hand the full beat to the write register; the next beat fills meanwhile.
                            r_wdata         <= w_beat;
                            r_en            <= 1'b1;
                            r_we            <= 1'b1;
                            r_addr          <= BRAM_AW'(r_beat_idx);
                            r_beat_idx      <= r_beat_idx + LENGTH_W'(1);
                            r_beats_written <= r_beats_written + LENGTH_W'(1);
                            r_acc           <= '0;
                            r_lane          <= '0;
                            if (w_final || s_in.in_last) begin
                                r_in_ready <= 1'b0;
                                r_state    <= FIN;
                                if (!w_final) begin
                                    r_err <= 1'b1;
                                end
                            end
                        end else begin
                            r_acc  <= w_beat;
                            r_lane <= r_lane + LANE_W'(1);
                            if (s_in.in_last) begin
                                r_err      <= 1'b1;
                                r_in_ready <= 1'b0;
                                r_state    <= FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    // Partial beat: unfilled lanes are still zero in the accumulator.
                    r_wdata         <= r_acc;
                    r_en            <= 1'b1;
                    r_we            <= 1'b1;
                    r_addr          <= BRAM_AW'(r_beat_idx);
                    r_beat_idx      <= r_beat_idx + LENGTH_W'(1);
                    r_beats_written <= r_beats_written + LENGTH_W'(1);
                    r_acc           <= '0;
                    r_lane          <= '0;
                    r_state         <= FIN;
                end
                FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_in.in_ready = r_in_ready;
    assign bram_c_addr   = r_addr;
    assign bram_c_en     = r_en;
    assign bram_c_we     = r_we;
    assign bram_c_wdata  = r_wdata;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err_short     = r_err;
    assign beats_written = r_beats_written;

endmodule

// File: tb/tb_c_result_packer.sv
// Scoreboard bench for c_result_packer: expected BRAM C writes and done pulses
// are queued by the stimulus and checked by an independent monitor.
module tb_c_result_packer;
    import mm_pkg::*;

    localparam int unsigned EW = 32;
    localparam int unsigned BW = 128;
    localparam int unsigned LW = 8;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] num_beats;
    logic [AW-1:0] bram_c_addr;
    logic          bram_c_en;
    logic          bram_c_we;
    logic [BW-1:0] bram_c_wdata;
    logic          busy;
    logic          done;
    logic          err_short;
    logic [LW-1:0] beats_written;

    c_result_packer_if #(.ELEM_W(EW)) s_if ();

    always #5 clk = ~clk;

    c_result_packer #(
        .ELEM_W(EW), .BEAT_W(BW), .LENGTH_W(LW), .BRAM_AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_beats(num_beats), .s_in(s_if),
        .bram_c_addr(bram_c_addr), .bram_c_en(bram_c_en), .bram_c_we(bram_c_we),
        .bram_c_wdata(bram_c_wdata), .busy(busy), .done(done),
        .err_short(err_short), .beats_written(beats_written)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } wr_t;

    typedef struct {
        int            cyc;
        logic [LW-1:0] bw;
        logic          err;
        bit            chk;
    } dn_t;

    wr_t exp_wr[$];
    dn_t exp_dn[$];
    wr_t w_m;
    dn_t d_m;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    function automatic void push_wr(input logic [AW-1:0] a, input logic [BW-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
    endfunction

    function automatic void push_dn(input int c, input logic [LW-1:0] b, input logic e, input bit k);
        dn_t d;
        d.cyc = c;
        d.bw  = b;
        d.err = e;
        d.chk = k;
        exp_dn.push_back(d);
    endfunction

    // Monitor: checks every write strobe and done pulse against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bram_c_we) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0h data %0h want none", bram_c_addr, bram_c_wdata);
                end else begin
                    w_m = exp_wr.pop_front();
                    check("wr_en", BW'(bram_c_en), BW'(1));
                    check("wr_addr", BW'(bram_c_addr), BW'(w_m.addr));
                    check("wr_data", bram_c_wdata, w_m.data);
                end
            end
            if (done) begin
                if (exp_dn.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done at cycle %0d want none", cyc);
                end else begin
                    d_m = exp_dn.pop_front();
                    check("done_cycle", BW'(cyc), BW'(d_m.cyc));
                    check("done_busy", BW'(busy), BW'(0));
                    check("done_pending_writes", BW'(exp_wr.size()), BW'(0));
                    if (d_m.chk) begin
                        check("done_beats_written", BW'(beats_written), BW'(d_m.bw));
                        check("done_err_short", BW'(err_short), BW'(d_m.err));
                    end
                end
            end
        end
    end

    task automatic do_start(input logic [LW-1:0] nb);
        start     = 1'b1;
        num_beats = nb;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Offer one element; n returns the cycle stamp seen just before the accepting edge.
    task automatic send(input logic [EW-1:0] d, input logic last, output int n);
        int k;
        s_if.in_valid = 1'b1;
        s_if.in_data  = d;
        s_if.in_last  = last;
        k = 0;
        while (!s_if.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!s_if.in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL in_ready_timeout: got in_ready=0 want 1 within 20 cycles");
        end
        n = cyc;
        @(posedge clk);
        @(negedge clk);
        s_if.in_valid = 1'b0;
        s_if.in_last  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((exp_dn.size() != 0 || exp_wr.size() != 0) && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        if (exp_dn.size() != 0 || exp_wr.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d writes %0d dones pending want 0", name, exp_wr.size(), exp_dn.size());
            exp_wr.delete();
            exp_dn.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},   BW'(busy),          BW'(0));
        check({tag, "_done"},   BW'(done),          BW'(0));
        check({tag, "_we"},     BW'(bram_c_we),     BW'(0));
        check({tag, "_en"},     BW'(bram_c_en),     BW'(0));
        check({tag, "_addr"},   BW'(bram_c_addr),   BW'(0));
        check({tag, "_wdata"},  bram_c_wdata,       BW'(0));
        check({tag, "_err"},    BW'(err_short),     BW'(0));
        check({tag, "_bw"},     BW'(beats_written), BW'(0));
        check({tag, "_ready"},  BW'(s_if.in_ready), BW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst           = 1'b1;
        start         = 1'b0;
        num_beats     = '0;
        s_if.in_valid = 1'b0;
        s_if.in_data  = '0;
        s_if.in_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Two full beats, back-to-back elements.
        push_wr(8'd0, {32'h4, 32'h3, 32'h2, 32'h1});
        push_wr(8'd1, {32'h8, 32'h7, 32'h6, 32'h5});
        do_start(8'd2);
        check("t1_busy_after_start", BW'(busy), BW'(1));
        for (int i = 1; i <= 8; i++) send(EW'(i), 1'b0, n);
        push_dn(n + 2, 8'd2, 1'b0, 1'b1);
        wait_idle("t1");
        check("t1_ready_idle", BW'(s_if.in_ready), BW'(0));

        // Early in_last mid-beat: partial beat flushed with zero lanes.
        push_wr(8'd0, {32'h4, 32'h3, 32'h2, 32'h1});
        push_wr(8'd1, {32'h0, 32'h0, 32'h6, 32'h5});
        do_start(8'd3);
        for (int i = 1; i <= 6; i++) send(EW'(i), (i == 6), n);
        push_dn(n + 3, 8'd2, 1'b1, 1'b1);
        wait_idle("t2");

        // Single beat with gaps in in_valid; err_short cleared by the new start.
        push_wr(8'd0, {32'hD, 32'hC, 32'hB, 32'hA});
        do_start(8'd1);
        for (int i = 0; i < 4; i++) begin
            send(EW'(32'hA + i), 1'b0, n);
            @(negedge clk);
        end
        push_dn(n + 2, 8'd1, 1'b0, 1'b1);
        wait_idle("t3");

        // Early in_last exactly on a beat boundary: no flush beat.
        push_wr(8'd0, {32'h4, 32'h3, 32'h2, 32'h1});
        do_start(8'd3);
        for (int i = 1; i <= 4; i++) send(EW'(i), (i == 4), n);
        push_dn(n + 2, 8'd1, 1'b1, 1'b1);
        wait_idle("t4");

        // Zero-beat job: done next cycle, never busy, no writes.
        push_dn(cyc + 1, 8'd0, 1'b0, 1'b0);
        do_start(8'd0);
        for (int i = 0; i < 3; i++) begin
            check("t5_busy", BW'(busy), BW'(0));
            @(negedge clk);
        end
        wait_idle("t5");

        // Reset mid-beat discards the partial beat.
        do_start(8'd1);
        send(32'h99, 1'b0, n);
        send(32'h98, 1'b0, n);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
        @(negedge clk);
        push_wr(8'd0, {32'h14, 32'h13, 32'h12, 32'h11});
        do_start(8'd1);
        for (int i = 0; i < 4; i++) send(EW'(32'h11 + i), 1'b0, n);
        push_dn(n + 2, 8'd1, 1'b0, 1'b1);
        wait_idle("t6");

        // Negative elements: zeroed only when the ReLU build option is on.
`ifdef C_PACK_RELU_EN
        push_wr(8'd0, {32'h3, 32'h0, 32'h7, 32'h0});
`else
        push_wr(8'd0, {32'h3, 32'h80000000, 32'h7, 32'hFFFFFFFB});
`endif
        do_start(8'd1);
        send(32'hFFFFFFFB, 1'b0, n);
        send(32'h7, 1'b0, n);
        send(32'h80000000, 1'b0, n);
        send(32'h3, 1'b0, n);
        push_dn(n + 2, 8'd1, 1'b0, 1'b1);
        wait_idle("t7");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
